spi_slave_core: RTL and testbench

SPI slave serial engine placed directly after the per-signal synchronizers. It takes the already-synchronized `sclk`, `cs_n` and `mosi` levels and detects SCLK edges in the system clock domain. It deserializes MOSI into parallel words behind a valid/ready handshake, and serializes words from a one-entry transmit holding register onto MISO. The SPI mode is selected by parameter.

---
 rtl/spi_slave_core.sv | 88 ++++++++
 tb/tb_spi_slave_core.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_core.sv
// spi_slave_core: SPI slave serial engine with rx/tx valid-ready handshakes
module spi_slave_core #(
  parameter int DATA_WIDTH = 8,
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk_s,
  input  logic                  cs_n_s,
  input  logic                  mosi_s,
  output logic                  miso,
  output logic                  miso_oe,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  rx_overrun,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_underrun
);
  localparam int CW = $clog2(DATA_WIDTH);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_d;
  logic sclk_q, rise, fall, samp, shft, start, abort, act, done, load, wr, hold_full, load_pending;
  logic [CW-1:0] bit_cnt;
  logic [DATA_WIDTH-1:0] tx_shift, hold, rx_word;
  logic [DATA_WIDTH-2:0] rx_shift;
  always_comb begin
    state_d = cs_n_s ? IDLE : ACTIVE;
    rise = sclk_s & ~sclk_q;
    fall = ~sclk_s & sclk_q;
    samp = (CPOL ^ CPHA) ? fall : rise;
    shft = (CPOL ^ CPHA) ? rise : fall;
    start = (state == IDLE) && !cs_n_s;
    abort = (state == ACTIVE) && cs_n_s;
    act = (state == ACTIVE) && !cs_n_s;
    done = act && samp && (bit_cnt == CW'(DATA_WIDTH-1));
    load = start || (act && shft && load_pending);
    wr = tx_valid && !hold_full;
    rx_word = {rx_shift, mosi_s};
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q <= 1'b0;
      miso_oe <= 1'b0;
      rx_overrun <= 1'b0;
      tx_underrun <= 1'b0;
      rx_valid <= 1'b0;
      hold_full <= 1'b0;
      hold <= '0;
      tx_shift <= '0;
      rx_data <= '0;
      rx_shift <= '0;
      bit_cnt <= '0;
      load_pending <= 1'b0;
    end else begin
      sclk_q <= sclk_s;
      miso_oe <= !cs_n_s;
      rx_overrun <= done && rx_valid && !rx_ready;
      tx_underrun <= load && !hold_full;
      rx_valid <= done || (rx_valid && !rx_ready);
      hold_full <= wr || (hold_full && !load);
      if (wr) hold <= tx_data;
      if (load) tx_shift <= hold_full ? hold : '0;
      else if (act && shft && (!CPHA || bit_cnt != '0)) tx_shift <= tx_shift << 1;
      if (done) rx_data <= rx_word;
      if (abort) begin
        bit_cnt <= '0;
        load_pending <= 1'b0;
        rx_shift <= '0;
      end else begin
        if (act && samp) begin
          rx_shift <= rx_word[DATA_WIDTH-2:0];
          bit_cnt <= done ? '0 : bit_cnt + 1'b1;
        end
        load_pending <= done || (load_pending && !load);
      end
    end
  end
  assign miso = tx_shift[DATA_WIDTH-1];
  assign tx_ready = !hold_full;
endmodule

// File: tb/tb_spi_slave_core.sv
// tb_spi_slave_core: mode 0 and mode 3 instances checked against a word-level reference model
module tb_spi_slave_core;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b1, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic rx_ready = 1'b0, tx_valid = 1'b0, rnd = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic miso_w [2], oe_w [2], rxv_w [2], ovr_w [2], txr_w [2], und_w [2];
  logic [W-1:0] rxd_w [2];
  int tests = 0, fails = 0;
  int und_n [2] = '{0, 0}, ovr_n [2] = '{0, 0}, rv_n [2] = '{0, 0};
  logic rv_p [2] = '{1'b0, 1'b0};
  logic m_sel [2], m_sp [2], m_pend [2], m_hf [2], m_rxv [2], m_ovr [2], m_und [2], m_oe [2];
  int m_nb [2], m_acc [2], m_txw [2], m_tpos [2], m_hold [2], m_rxd [2];
  always #5 clk = ~clk;
  spi_slave_core #(.DATA_WIDTH(W), .CPOL(1'b0), .CPHA(1'b0)) dut0 (
    .clk(clk), .rst(rst), .sclk_s(sclk), .cs_n_s(cs_n), .mosi_s(mosi),
    .miso(miso_w[0]), .miso_oe(oe_w[0]), .rx_data(rxd_w[0]), .rx_valid(rxv_w[0]),
    .rx_ready(rx_ready), .rx_overrun(ovr_w[0]), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(txr_w[0]), .tx_underrun(und_w[0])
  );
  spi_slave_core #(.DATA_WIDTH(W), .CPOL(1'b1), .CPHA(1'b1)) dut3 (
    .clk(clk), .rst(rst), .sclk_s(~sclk), .cs_n_s(cs_n), .mosi_s(mosi),
    .miso(miso_w[1]), .miso_oe(oe_w[1]), .rx_data(rxd_w[1]), .rx_valid(rxv_w[1]),
    .rx_ready(rx_ready), .rx_overrun(ovr_w[1]), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(txr_w[1]), .tx_underrun(und_w[1])
  );
  always @(posedge clk) begin : model
    logic s, ld, wr, got;
    for (int k = 0; k < 2; k++) begin
      s = (k == 1) ? ~sclk : sclk;
      if (rst) begin
        m_sel[k] = 0; m_sp[k] = 0; m_pend[k] = 0; m_hf[k] = 0; m_rxv[k] = 0;
        m_ovr[k] = 0; m_und[k] = 0; m_oe[k] = 0; m_nb[k] = 0; m_acc[k] = 0;
        m_txw[k] = 0; m_tpos[k] = 0; m_hold[k] = 0; m_rxd[k] = 0;
      end else begin
        wr = tx_valid && !m_hf[k];
        ld = 0;
        got = 0;
        m_ovr[k] = 0;
        m_und[k] = 0;
        if (!m_sel[k] && !cs_n) ld = 1;
        else if (m_sel[k] && cs_n) begin
          m_nb[k] = 0; m_acc[k] = 0; m_pend[k] = 0;
        end else if (m_sel[k]) begin
          if (s && !m_sp[k]) begin
            m_acc[k] = m_acc[k] * 2 + int'(mosi);
            m_nb[k]++;
            if (m_nb[k] == W) begin
              m_ovr[k] = m_rxv[k] && !rx_ready;
              m_rxd[k] = m_acc[k];
              got = 1; m_nb[k] = 0; m_acc[k] = 0; m_pend[k] = 1;
            end
          end else if (!s && m_sp[k]) begin
            if (m_pend[k]) begin
              ld = 1; m_pend[k] = 0;
            end else if (k == 0 || m_nb[k] != 0) m_tpos[k]++;
          end
        end
        m_rxv[k] = got ? 1'b1 : (m_rxv[k] && rx_ready) ? 1'b0 : m_rxv[k];
        if (ld) begin
          m_txw[k] = m_hf[k] ? m_hold[k] : 0;
          m_und[k] = !m_hf[k];
          m_hf[k] = 0;
          m_tpos[k] = 0;
        end
        if (wr) begin
          m_hold[k] = int'(tx_data); m_hf[k] = 1;
        end
        m_sel[k] = !cs_n;
        m_oe[k] = !cs_n;
        m_sp[k] = s;
      end
    end
  end
  function automatic logic exp_miso(input int k);
    return (m_tpos[k] < W) ? (((m_txw[k] >> (W - 1 - m_tpos[k])) & 1) != 0) : 1'b0;
  endfunction
  task automatic chk(input string nm, input int k, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, k, a, e, $time);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk("miso", k, 32'(miso_w[k]), 32'(exp_miso(k)));
        chk("miso_oe", k, 32'(oe_w[k]), 32'(m_oe[k]));
        chk("rx_data", k, 32'(rxd_w[k]), m_rxd[k]);
        chk("rx_valid", k, 32'(rxv_w[k]), 32'(m_rxv[k]));
        chk("rx_overrun", k, 32'(ovr_w[k]), 32'(m_ovr[k]));
        chk("tx_ready", k, 32'(txr_w[k]), 32'(!m_hf[k]));
        chk("tx_underrun", k, 32'(und_w[k]), 32'(m_und[k]));
        und_n[k] += int'(und_w[k]);
        ovr_n[k] += int'(ovr_w[k]);
        if (rxv_w[k] && !rv_p[k]) rv_n[k]++;
        rv_p[k] = rxv_w[k];
      end
      @(posedge clk);
      #1;
      if (rnd) begin
        rx_ready = 1'($urandom_range(0, 1));
        tx_valid = ($urandom_range(0, 2) == 0);
        tx_data = W'($urandom);
      end
    end
  endtask
  task automatic put(input logic [W-1:0] d);
    tx_data = d;
    tx_valid = 1'b1;
    step(1);
    tx_valid = 1'b0;
  endtask
  task automatic xfer(input logic [W-1:0] mo, input int nbits, output logic [W-1:0] m0, output logic [W-1:0] m3);
    m0 = '0;
    m3 = '0;
    for (int i = W - 1; i >= W - nbits; i--) begin
      step(1);
      mosi = mo[i];
      step(rnd ? int'($urandom_range(2, 4)) : 2);
      m0[i] = miso_w[0];
      sclk = 1'b1;
      step(rnd ? int'($urandom_range(2, 4)) : 3);
      m3[i] = miso_w[1];
      sclk = 1'b0;
    end
  endtask
  initial begin
    logic [W-1:0] m0, m3;
    int u [2], o [2], r [2];
    step(3);
    rst = 1'b0;
    step(3);
    put(8'hA5);
    cs_n = 1'b0;
    u = und_n;
    xfer(8'h3C, W, m0, m3);
    for (int k = 0; k < 2; k++) chk("t1_underrun", k, und_n[k] - u[k], 0);
    step(2);
    for (int k = 0; k < 2; k++) begin
      chk("t1_rx_data", k, 32'(rxd_w[k]), 32'h3C);
      chk("t1_rx_valid", k, 32'(rxv_w[k]), 1);
    end
    chk("t1_model_rx", 0, m_rxd[0], 32'h3C);
    chk("t1_miso", 0, 32'(m0), 32'hA5);
    chk("t1_miso", 1, 32'(m3), 32'hA5);
    cs_n = 1'b1;
    step(3);
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    put(8'h5E);
    cs_n = 1'b0;
    step(2);
    put(8'h81);
    o = ovr_n;
    xfer(8'h12, W, m0, m3);
    xfer(8'h34, W, m0, m3);
    step(2);
    for (int k = 0; k < 2; k++) begin
      chk("t2_rx_data", k, 32'(rxd_w[k]), 32'h34);
      chk("t2_overruns", k, ovr_n[k] - o[k], 1);
    end
    chk("t2_miso", 0, 32'(m0), 32'h81);
    chk("t2_miso", 1, 32'(m3), 32'h81);
    cs_n = 1'b1;
    step(3);
    rx_ready = 1'b1;
    u = und_n;
    cs_n = 1'b0;
    xfer(8'h96, W, m0, m3);
    for (int k = 0; k < 2; k++) begin
      chk("t3_underruns", k, und_n[k] - u[k], 1);
      chk("t3_tx_ready", k, 32'(txr_w[k]), 1);
    end
    chk("t3_miso", 0, 32'(m0), 0);
    chk("t3_miso", 1, 32'(m3), 0);
    step(2);
    cs_n = 1'b1;
    step(3);
    put(8'hC3);
    cs_n = 1'b0;
    xfer(8'h5A, W, m0, m3);
    step(2);
    for (int k = 0; k < 2; k++) chk("t4_rx_data", k, 32'(rxd_w[k]), 32'h5A);
    chk("t4_miso", 0, 32'(m0), 32'hC3);
    chk("t4_miso", 1, 32'(m3), 32'hC3);
    cs_n = 1'b1;
    step(3);
    r = rv_n;
    cs_n = 1'b0;
    xfer(8'hB7, 5, m0, m3);
    step(2);
    cs_n = 1'b1;
    step(2);
    for (int k = 0; k < 2; k++) begin
      chk("t5_abort_rx_valid", k, rv_n[k] - r[k], 0);
      chk("t5_miso_oe", k, 32'(oe_w[k]), 0);
    end
    cs_n = 1'b0;
    xfer(8'hFF, W, m0, m3);
    step(2);
    for (int k = 0; k < 2; k++) chk("t5_rx_data", k, 32'(rxd_w[k]), 32'hFF);
    cs_n = 1'b1;
    step(3);
    cs_n = 1'b0;
    step(2);
    put(8'h77);
    xfer(8'h6D, 4, m0, m3);
    rst = 1'b1;
    step(1);
    for (int k = 0; k < 2; k++)
      chk("t6_reset_outputs", k, 32'({miso_w[k], oe_w[k], rxd_w[k], rxv_w[k], ovr_w[k], txr_w[k], und_w[k]}), 32'h002);
    cs_n = 1'b1;
    step(2);
    rst = 1'b0;
    step(3);
    rnd = 1'b1;
    for (int f = 0; f < 50; f++) begin
      int nw;
      cs_n = 1'b0;
      nw = int'($urandom_range(1, 3));
      for (int w = 0; w < nw; w++)
        xfer(W'($urandom), (w == nw - 1 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, W - 1)) : W, m0, m3);
      step(int'($urandom_range(1, 3)));
      cs_n = 1'b1;
      step(int'($urandom_range(2, 4)));
    end
    rnd = 1'b0;
    tx_valid = 1'b0;
    rx_ready = 1'b1;
    step(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
